// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel-fetch stage.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned FB_WORDS = 307200;

  typedef logic [3:0] pix_idx_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } swap_state_e;

  // Linear pixel offset row*640+col using shifts only (row*512 + row*128 + col).
  function automatic logic [18:0] fb_offset(input logic [8:0] row, input logic [9:0] col);
    return (19'(row) << 9) + (19'(row) << 7) + 19'(col);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Resettable fixed-depth shift register; reset value set by RST_VAL.
module vga_delay_line #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Frame-buffer fetch, colour map and sync re-alignment with vsync-timed buffer swap.
// Optional writable palette when VGA_FETCH_PALETTE_EN is defined.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        row,
  input  logic [9:0]        col,
  input  logic              en_r,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [3:0]        fb_rdata,
`ifdef VGA_FETCH_PALETTE_EN
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_data,
`endif
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              back_buf,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync,
  output logic              vsync
);

  localparam int unsigned OFF_W    = ADDR_W - 1;
  localparam int unsigned DL_DEPTH = RD_LAT + 1;

  swap_state_e state, state_next;
  logic        front_buf, front_next, ack_next;
  logic        vs_prev, vs_fall;
  logic [2:0]  dl_q;
  rgb_t        lut;

  assign vs_fall = vs_prev & ~vsync_in;

  // Swap state register and its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      front_buf <= 1'b0;
      back_buf  <= 1'b1;
      swap_ack  <= 1'b0;
      vs_prev   <= 1'b1;
    end else begin
      state     <= state_next;
      front_buf <= front_next;
      back_buf  <= ~front_next;
      swap_ack  <= ack_next;
      vs_prev   <= vsync_in;
    end
  end

  // A request seen in IDLE always waits for the next falling vsync, even a coincident one.
  always_comb begin
    state_next = state;
    front_next = front_buf;
    ack_next   = 1'b0;
    case (state)
      IDLE:    if (swap_req) state_next = PENDING;
      PENDING: if (vs_fall) begin
        state_next = SWAP;
        front_next = ~front_buf;
        ack_next   = 1'b1;
      end
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage A: address generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_addr  <= '0;
      fb_rd_en <= 1'b0;
    end else begin
      fb_addr  <= {front_buf, OFF_W'(fb_offset(row, col))};
      fb_rd_en <= en_r;
    end
  end

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (DL_DEPTH),
    .RST_VAL(3'b011)
  ) u_sync_dl (
    .clk(clk),
    .rst(rst),
    .d  ({en_r, hsync_in, vsync_in}),
    .q  (dl_q)
  );

`ifdef VGA_FETCH_PALETTE_EN
  rgb_t palette [16];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) palette[i] <= '{r: 4'h0, g: 4'(i), b: 4'h0};
    end else if (pal_we) begin
      palette[pal_idx] <= rgb_t'(pal_data);
    end
  end

  always_comb lut = palette[fb_rdata];
`else
  always_comb lut = '{r: 4'h0, g: fb_rdata, b: 4'h0};
`endif

  // Output stage: colour lookup with blanking, syncs aligned to the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r <= 4'h0;
      vga_g <= 4'h0;
      vga_b <= 4'h0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      vga_r <= dl_q[2] ? lut.r : 4'h0;
      vga_g <= dl_q[2] ? lut.g : 4'h0;
      vga_b <= dl_q[2] ? lut.b : 4'h0;
      hsync <= dl_q[1];
      vsync <= dl_q[0];
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: fb memory model plus a latency-queue reference.
module tb_vga_pixel_fetch;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned LAT    = RD_LAT + 2;

  logic        clk, rst;
  logic [8:0]  row;
  logic [9:0]  col;
  logic        en_r, hsync_in, vsync_in;
  logic [19:0] fb_addr;
  logic        fb_rd_en;
  logic [3:0]  fb_rdata;
  logic        swap_req, swap_ack, back_buf;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync;
`ifdef VGA_FETCH_PALETTE_EN
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [11:0] pal_data;
`endif

  vga_pixel_fetch #(.RD_LAT(RD_LAT), .ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .en_r(en_r),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_rdata(fb_rdata),
`ifdef VGA_FETCH_PALETTE_EN
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
`endif
    .swap_req(swap_req), .swap_ack(swap_ack), .back_buf(back_buf),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       hs;
    logic       vs;
    logic [3:0] pix;
  } ent_t;

  ent_t        hist[$];
  int          tests = 0;
  int          fails = 0;
  logic        exp_bank;
  logic        force_en = 1'b0;
  logic [3:0]  force_val = 4'h0;
  logic [11:0] pal_m [16];
  logic [3:0]  rd_pipe [RD_LAT];

  // Frame-buffer contents: a fixed hash of the address unless overridden.
  function automatic logic [3:0] pix(input logic [19:0] a);
    if (force_en) return force_val;
    return a[3:0] ^ a[10:7] ^ {a[19], a[14:12]};
  endfunction

  function automatic logic [11:0] cmap(input logic [3:0] p);
`ifdef VGA_FETCH_PALETTE_EN
    return pal_m[p];
`else
    return {4'h0, p, 4'h0};
`endif
  endfunction

  // Memory with RD_LAT cycles from registered address to data.
  always_ff @(posedge clk) begin
    rd_pipe[0] <= pix(fb_addr);
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en_r = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; row = '0; col = '0;
    swap_req = 1'b0;
`ifdef VGA_FETCH_PALETTE_EN
    pal_we = 1'b0; pal_idx = '0; pal_data = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fb_addr", 32'(fb_addr), 32'h0);
    chk("rst_fb_rd_en", 32'(fb_rd_en), 32'h0);
    chk("rst_swap_ack", 32'(swap_ack), 32'h0);
    chk("rst_back_buf", 32'(back_buf), 32'h1);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_syncs", 32'({hsync, vsync}), 32'h3);
    rst = 1'b0;
    exp_bank = 1'b0;
    for (int i = 0; i < 16; i++) pal_m[i] = {4'h0, 4'(i), 4'h0};
    hist.delete();
    for (int i = 0; i < int'(LAT) - 1; i++) hist.push_back('{en: 1'b0, hs: 1'b1, vs: 1'b1, pix: 4'h0});
  endtask

  // One clock of stimulus; checks stage A now and outputs for the input LAT-1 steps back.
  task automatic step(input logic en, input logic hs, input logic vs,
                      input int unsigned r, input int unsigned c);
    logic [19:0] a;
    ent_t        e;
    logic [11:0] exp_rgb;
    row = 9'(r); col = 10'(c); en_r = en; hsync_in = hs; vsync_in = vs;
    a = {exp_bank, 19'(r * 640 + c)};
    hist.push_back('{en: en, hs: hs, vs: vs, pix: pix(a)});
    @(posedge clk);
    @(negedge clk);
    chk("fb_addr", 32'(fb_addr), 32'(a));
    chk("fb_rd_en", 32'(fb_rd_en), 32'(en));
    if (hist.size() == int'(LAT)) begin
      e = hist.pop_front();
      exp_rgb = e.en ? cmap(e.pix) : 12'h0;
      chk("vga_r", 32'(vga_r), 32'(exp_rgb[11:8]));
      chk("vga_g", 32'(vga_g), 32'(exp_rgb[7:4]));
      chk("vga_b", 32'(vga_b), 32'(exp_rgb[3:0]));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
    end
  endtask

  initial begin
    // Reset state
    do_reset();

    // Address arithmetic corners
    step(1'b1, 1'b1, 1'b1, 1, 0);
    chk("addr_row1", 32'(fb_addr), 32'd640);
    step(1'b1, 1'b1, 1'b1, 479, 639);
    chk("addr_max", 32'(fb_addr), 32'd307199);
    step(1'b0, 1'b1, 1'b1, 0, 0);

    // Latency and sync alignment with constant pixel 0xA
    force_en = 1'b1; force_val = 4'hA;
    repeat (LAT) step(1'b0, 1'b1, 1'b1, 5, 5);
    step(1'b1, 1'b0, 1'b1, 10, 20);
    step(1'b0, 1'b1, 1'b0, 10, 21);
    step(1'b0, 1'b1, 1'b1, 10, 22);
    step(1'b0, 1'b1, 1'b1, 10, 23);
    chk("lat_vga_g_pulse", 32'(vga_g), 32'hA);
    chk("lat_hsync_pulse", 32'(hsync), 32'h0);
    step(1'b0, 1'b1, 1'b1, 10, 24);
    chk("lat_vga_g_blank", 32'(vga_g), 32'h0);
    chk("lat_vsync_pulse", 32'(vsync), 32'h0);
    repeat (LAT) step(1'b0, 1'b1, 1'b1, 0, 0);
    force_en = 1'b0;

    // Randomized video traffic, no swap requests
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(479, 0), $urandom_range(639, 0));

    // Swap requested mid-frame: acked only at vsync fall
    do_reset();
    swap_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 100, i);
      chk("swap_wait_ack", 32'(swap_ack), 32'h0);
      chk("swap_wait_back", 32'(back_buf), 32'h1);
    end
    step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("swap_ack_pulse", 32'(swap_ack), 32'h1);
    chk("swap_back_after", 32'(back_buf), 32'h0);
    swap_req = 1'b0;
    exp_bank = 1'b1;
    step(1'b1, 1'b1, 1'b0, 2, 3);
    chk("swap_ack_clear", 32'(swap_ack), 32'h0);
    chk("swap_bank_bit", 32'(fb_addr[19]), 32'h1);
    step(1'b1, 1'b1, 1'b0, 7, 9);

    // Reset while pending discards the swap
    step(1'b0, 1'b1, 1'b1, 0, 0);
    swap_req = 1'b1;
    step(1'b0, 1'b1, 1'b1, 0, 1);
    swap_req = 1'b0;
    step(1'b0, 1'b1, 1'b1, 0, 2);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0);
      chk("rst_pend_no_ack", 32'(swap_ack), 32'h0);
      chk("rst_pend_back", 32'(back_buf), 32'h1);
    end

    // Request coincident with vsync fall: swap waits a full frame
    step(1'b0, 1'b1, 1'b1, 0, 0);
    swap_req = 1'b1;
    step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("coinc_no_ack", 32'(swap_ack), 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, (i < 3) ? 1'b0 : 1'b1, 1, i);
      chk("coinc_wait_ack", 32'(swap_ack), 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("coinc_ack", 32'(swap_ack), 32'h1);
    chk("coinc_back", 32'(back_buf), 32'h0);
    swap_req = 1'b0;
    exp_bank = 1'b1;
    step(1'b1, 1'b1, 1'b0, 3, 3);
    chk("coinc_ack_clear", 32'(swap_ack), 32'h0);

    // Colour map: palette entry 3 rewritten, or fixed green map
    do_reset();
`ifdef VGA_FETCH_PALETTE_EN
    pal_we = 1'b1; pal_idx = 4'd3; pal_data = 12'hF80;
    step(1'b0, 1'b1, 1'b1, 0, 0);
    pal_we = 1'b0;
    pal_m[3] = 12'hF80;
`endif
    force_en = 1'b1; force_val = 4'd3;
    repeat (LAT) step(1'b0, 1'b1, 1'b1, 0, 0);
    step(1'b1, 1'b1, 1'b1, 4, 4);
    repeat (LAT - 1) step(1'b0, 1'b1, 1'b1, 0, 0);
`ifdef VGA_FETCH_PALETTE_EN
    chk("pal_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0F80);
`else
    chk("mono_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0030);
`endif
    repeat (LAT) step(1'b0, 1'b1, 1'b1, 0, 0);
    force_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
